// File: rtl/l1_l2_arbiter_if.sv
// l1_l2_arbiter_if: L1<->L2 request/response bundle; l1_side issues requests, l2_side answers them.
interface l1_l2_intf #(parameter int ADDR_W = 32);
    logic              l1_req_valid;
    logic [ADDR_W-1:0] l1_req_addr;
    logic              l1_req_op;
    logic [ADDR_W-1:0] l1_write_data;
    logic              l2_resp_valid;
    logic [ADDR_W-1:0] l2_resp_data;
    logic              l2_miss;
    modport l1_side (output l1_req_valid, l1_req_addr, l1_req_op, l1_write_data,
                     input  l2_resp_valid, l2_resp_data, l2_miss);
    modport l2_side (input  l1_req_valid, l1_req_addr, l1_req_op, l1_write_data,
                     output l2_resp_valid, l2_resp_data, l2_miss);
endinterface

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: round-robin arbiter sharing one L2 port between two L1 requesters, with optional timeout.
module l1_l2_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic rst,
    l1_l2_intf.l2_side req0,
    l1_l2_intf.l2_side req1,
    l1_l2_intf.l1_side l2,
    output logic busy,
    output logic grant_id,
    output logic timeout_err
);
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_n;
    logic rr, sel, any, in_wait, tmo, fire, fire0, fire1;
    logic [CW-1:0] cnt;
    logic [ADDR_W-1:0] addr_q, wdata_q, rdata;
    logic op_q;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // Outputs are gated with rst so the bus is quiet during the reset cycle itself.
    always_comb begin
        any = req0.l1_req_valid || req1.l1_req_valid;
        sel = rr ? req1.l1_req_valid : !req0.l1_req_valid;
        in_wait = state == WAIT && !rst;
        tmo = TIMEOUT_CYCLES != 0 && cnt == TMAX && !l2.l2_resp_valid;
        fire = in_wait && (l2.l2_resp_valid || tmo);
        fire0 = fire && !grant_id;
        fire1 = fire && grant_id;
        rdata = tmo ? '0 : l2.l2_resp_data;
        state_n = state == IDLE ? (any ? WAIT : IDLE) : state == WAIT ? (fire ? DONE : WAIT) : IDLE;
        l2.l1_req_valid = in_wait;
        l2.l1_req_addr = in_wait ? addr_q : '0;
        l2.l1_req_op = in_wait && op_q;
        l2.l1_write_data = in_wait ? wdata_q : '0;
        req0.l2_resp_valid = fire0;
        req0.l2_resp_data = fire0 ? rdata : '0;
        req0.l2_miss = fire0 && (tmo || l2.l2_miss);
        req1.l2_resp_valid = fire1;
        req1.l2_resp_data = fire1 ? rdata : '0;
        req1.l2_miss = fire1 && (tmo || l2.l2_miss);
        busy = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= 1'b0;
            grant_id <= 1'b0;
            timeout_err <= 1'b0;
            cnt <= '0;
            addr_q <= '0;
            op_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            if (state == IDLE && any) begin
                grant_id <= sel;
                rr <= !sel;
                addr_q <= sel ? req1.l1_req_addr : req0.l1_req_addr;
                op_q <= sel ? req1.l1_req_op : req0.l1_req_op;
                wdata_q <= sel ? req1.l1_write_data : req0.l1_write_data;
                cnt <= '0;
            end else if (state == WAIT && TIMEOUT_CYCLES != 0) cnt <= cnt + 1'b1;
            if (fire && tmo) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb_l1_l2_arbiter: directed self-checking bench for l1_l2_arbiter (TIMEOUT_CYCLES=8).
module tb_l1_l2_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, grant_id, timeout_err;
    int total = 0;
    int passed = 0;
    l1_l2_intf #(.ADDR_W(32)) r0 ();
    l1_l2_intf #(.ADDR_W(32)) r1 ();
    l1_l2_intf #(.ADDR_W(32)) l2 ();

    l1_l2_arbiter #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req0(r0), .req1(r1), .l2(l2),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic test_reset;
        r0.l1_req_valid = 1'b1; r0.l1_req_addr = 32'h10; r0.l1_req_op = 1'b0; r0.l1_write_data = '0;
        r1.l1_req_valid = 1'b0; r1.l1_req_addr = '0; r1.l1_req_op = 1'b0; r1.l1_write_data = '0;
        l2.l2_resp_valid = 1'b0; l2.l2_resp_data = '0; l2.l2_miss = 1'b0;
        rst = 1'b1;
        tick; tick; smp;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        total++; if (grant_id !== 1'b0) $display("FAIL reset_grant got %b exp 0", grant_id); else passed++;
        total++; if (timeout_err !== 1'b0) $display("FAIL reset_terr got %b exp 0", timeout_err); else passed++;
        total++; if (l2.l1_req_valid !== 1'b0) $display("FAIL reset_l2_valid got %b exp 0", l2.l1_req_valid); else passed++;
        total++; if (l2.l1_req_addr !== 32'h0) $display("FAIL reset_l2_addr got %h exp 0", l2.l1_req_addr); else passed++;
        total++; if (r0.l2_resp_valid !== 1'b0 || r1.l2_resp_valid !== 1'b0)
            $display("FAIL reset_resp got %b%b exp 00", r0.l2_resp_valid, r1.l2_resp_valid); else passed++;
        tick;
        rst = 1'b0; r0.l1_req_valid = 1'b0;
        smp;
        total++; if (l2.l1_req_valid !== 1'b0) $display("FAIL post_reset_l2_valid got %b exp 0", l2.l1_req_valid); else passed++;
        tick; smp;
        total++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b exp 0", busy); else passed++;
    endtask

    task automatic test_single;
        tick;
        r1.l1_req_valid = 1'b1; r1.l1_req_addr = 32'h0000_1000; r1.l1_req_op = 1'b0;
        smp;
        total++; if (l2.l1_req_valid !== 1'b0) $display("FAIL single_n_valid got %b exp 0", l2.l1_req_valid); else passed++;
        tick; smp;
        total++; if (l2.l1_req_valid !== 1'b1) $display("FAIL single_n1_valid got %b exp 1", l2.l1_req_valid); else passed++;
        total++; if (l2.l1_req_addr !== 32'h1000) $display("FAIL single_n1_addr got %h exp 1000", l2.l1_req_addr); else passed++;
        total++; if (l2.l1_req_op !== 1'b0) $display("FAIL single_n1_op got %b exp 0", l2.l1_req_op); else passed++;
        total++; if (grant_id !== 1'b1) $display("FAIL single_grant got %b exp 1", grant_id); else passed++;
        tick; tick; smp;
        total++; if (l2.l1_req_valid !== 1'b1 || l2.l1_req_addr !== 32'h1000)
            $display("FAIL single_n3_hold got %b/%h exp 1/1000", l2.l1_req_valid, l2.l1_req_addr); else passed++;
        tick;
        l2.l2_resp_valid = 1'b1; l2.l2_resp_data = 32'hDEAD_BEEF; l2.l2_miss = 1'b0;
        smp;
        total++; if (r1.l2_resp_valid !== 1'b1) $display("FAIL single_resp_valid got %b exp 1", r1.l2_resp_valid); else passed++;
        total++; if (r1.l2_resp_data !== 32'hDEAD_BEEF) $display("FAIL single_resp_data got %h exp deadbeef", r1.l2_resp_data); else passed++;
        total++; if (r0.l2_resp_valid !== 1'b0) $display("FAIL single_r0_quiet got %b exp 0", r0.l2_resp_valid); else passed++;
        tick;
        l2.l2_resp_valid = 1'b0; r1.l1_req_valid = 1'b0;
        smp;
        total++; if (l2.l1_req_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_done got valid %b busy %b exp 0 1", l2.l1_req_valid, busy); else passed++;
        tick; smp;
        total++; if (busy !== 1'b0) $display("FAIL single_n6_busy got %b exp 0", busy); else passed++;
    endtask

    task automatic test_round_robin;
        logic e;
        logic [31:0] ea;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        r0.l1_req_valid = 1'b1; r0.l1_req_addr = 32'h100; r0.l1_req_op = 1'b0;
        r1.l1_req_valid = 1'b1; r1.l1_req_addr = 32'h200; r1.l1_req_op = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = (k % 2) == 1;
            ea = e ? 32'h200 : 32'h100;
            tick;
            l2.l2_resp_valid = 1'b1; l2.l2_resp_data = 32'hC000_0000 | ea;
            smp;
            total++; if (grant_id !== e) $display("FAIL rr_grant%0d got %b exp %b", k, grant_id, e); else passed++;
            total++; if (l2.l1_req_addr !== ea) $display("FAIL rr_addr%0d got %h exp %h", k, l2.l1_req_addr, ea); else passed++;
            total++; if (r0.l2_resp_valid !== !e || r1.l2_resp_valid !== e)
                $display("FAIL rr_resp%0d got %b%b exp %b%b", k, r0.l2_resp_valid, r1.l2_resp_valid, !e, e); else passed++;
            total++; if ((e ? r1.l2_resp_data : r0.l2_resp_data) !== (32'hC000_0000 | ea))
                $display("FAIL rr_data%0d got %h exp %h", k, e ? r1.l2_resp_data : r0.l2_resp_data, 32'hC000_0000 | ea); else passed++;
            total++; if ((e ? r0.l2_resp_data : r1.l2_resp_data) !== 32'h0)
                $display("FAIL rr_other_data%0d got %h exp 0", k, e ? r0.l2_resp_data : r1.l2_resp_data); else passed++;
            tick;
            l2.l2_resp_valid = 1'b0;
            if (k == 3) begin
                r0.l1_req_valid = 1'b0; r1.l1_req_valid = 1'b0;
            end
            smp;
            total++; if (l2.l1_req_valid !== 1'b0) $display("FAIL rr_done%0d got %b exp 0", k, l2.l1_req_valid); else passed++;
            tick; smp;
        end
    endtask

    task automatic test_timeout;
        tick;
        r0.l1_req_valid = 1'b1; r0.l1_req_addr = 32'h300; r0.l1_req_op = 1'b0;
        l2.l2_resp_data = 32'hFFFF_FFFF;
        for (int c = 1; c < 8; c++) begin
            tick; smp;
            total++; if (l2.l1_req_valid !== 1'b1 || r0.l2_resp_valid !== 1'b0)
                $display("FAIL tmo_wait%0d got valid %b resp %b exp 1 0", c, l2.l1_req_valid, r0.l2_resp_valid); else passed++;
        end
        tick; smp;
        total++; if (r0.l2_resp_valid !== 1'b1) $display("FAIL tmo_resp got %b exp 1", r0.l2_resp_valid); else passed++;
        total++; if (r0.l2_miss !== 1'b1) $display("FAIL tmo_miss got %b exp 1", r0.l2_miss); else passed++;
        total++; if (r0.l2_resp_data !== 32'h0) $display("FAIL tmo_data got %h exp 0", r0.l2_resp_data); else passed++;
        total++; if (r1.l2_resp_valid !== 1'b0) $display("FAIL tmo_r1_quiet got %b exp 0", r1.l2_resp_valid); else passed++;
        tick;
        r0.l1_req_valid = 1'b0;
        l2.l2_resp_valid = 1'b1; l2.l2_resp_data = 32'h55;
        smp;
        total++; if (l2.l1_req_valid !== 1'b0) $display("FAIL tmo_drop_req got %b exp 0", l2.l1_req_valid); else passed++;
        total++; if (timeout_err !== 1'b1) $display("FAIL tmo_err got %b exp 1", timeout_err); else passed++;
        total++; if (r0.l2_resp_valid !== 1'b0 || r1.l2_resp_valid !== 1'b0)
            $display("FAIL tmo_late_done got %b%b exp 00", r0.l2_resp_valid, r1.l2_resp_valid); else passed++;
        tick; smp;
        total++; if (r0.l2_resp_valid !== 1'b0 || r1.l2_resp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL tmo_late_idle got %b%b busy %b exp 00 0", r0.l2_resp_valid, r1.l2_resp_valid, busy); else passed++;
        tick;
        l2.l2_resp_valid = 1'b0;
        smp;
        total++; if (timeout_err !== 1'b1) $display("FAIL tmo_sticky got %b exp 1", timeout_err); else passed++;
    endtask

    task automatic test_late_drop;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        smp;
        total++; if (timeout_err !== 1'b0) $display("FAIL late_terr_clear got %b exp 0", timeout_err); else passed++;
        r1.l1_req_valid = 1'b1; r1.l1_req_addr = 32'h500; r1.l1_req_op = 1'b0;
        tick;
        l2.l2_resp_valid = 1'b1; l2.l2_resp_data = 32'h77;
        smp;
        total++; if (r1.l2_resp_valid !== 1'b1) $display("FAIL late_resp got %b exp 1", r1.l2_resp_valid); else passed++;
        tick;
        l2.l2_resp_valid = 1'b0;
        smp;
        total++; if (l2.l1_req_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL late_done got valid %b busy %b exp 0 1", l2.l1_req_valid, busy); else passed++;
        tick;
        r1.l1_req_valid = 1'b0;
        smp;
        total++; if (l2.l1_req_valid !== 1'b0) $display("FAIL late_idle got %b exp 0", l2.l1_req_valid); else passed++;
        tick; smp;
        total++; if (l2.l1_req_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL late_no_dup got valid %b busy %b exp 0 0", l2.l1_req_valid, busy); else passed++;
    endtask

    task automatic test_reset_mid_wait;
        r0.l1_req_valid = 1'b1; r0.l1_req_addr = 32'h600; r0.l1_req_op = 1'b0;
        tick; smp;
        total++; if (l2.l1_req_valid !== 1'b1 || grant_id !== 1'b0)
            $display("FAIL rmw_grant got valid %b id %b exp 1 0", l2.l1_req_valid, grant_id); else passed++;
        tick;
        rst = 1'b1; l2.l2_resp_valid = 1'b1; l2.l2_resp_data = 32'h99;
        smp;
        total++; if (l2.l1_req_valid !== 1'b0 || r0.l2_resp_valid !== 1'b0)
            $display("FAIL rmw_rst_cycle got valid %b resp %b exp 0 0", l2.l1_req_valid, r0.l2_resp_valid); else passed++;
        tick;
        rst = 1'b0;
        r1.l1_req_valid = 1'b1; r1.l1_req_addr = 32'h700; r1.l1_req_op = 1'b0;
        smp;
        total++; if (l2.l1_req_valid !== 1'b0 || r0.l2_resp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rmw_after got valid %b resp %b busy %b exp 0 0 0", l2.l1_req_valid, r0.l2_resp_valid, busy); else passed++;
        tick;
        l2.l2_resp_valid = 1'b0;
        smp;
        total++; if (grant_id !== 1'b0 || l2.l1_req_addr !== 32'h600)
            $display("FAIL rmw_regrant got id %b addr %h exp 0 600", grant_id, l2.l1_req_addr); else passed++;
        tick;
        l2.l2_resp_valid = 1'b1; l2.l2_resp_data = 32'hAB;
        smp;
        total++; if (r0.l2_resp_valid !== 1'b1 || r0.l2_resp_data !== 32'hAB)
            $display("FAIL rmw_resp got %b/%h exp 1/ab", r0.l2_resp_valid, r0.l2_resp_data); else passed++;
        tick;
        l2.l2_resp_valid = 1'b0; r0.l1_req_valid = 1'b0; r1.l1_req_valid = 1'b0;
        tick; smp;
        total++; if (busy !== 1'b0) $display("FAIL rmw_idle got %b exp 0", busy); else passed++;
    endtask

    task automatic test_write;
        r0.l1_req_valid = 1'b1; r0.l1_req_addr = 32'h40; r0.l1_req_op = 1'b1; r0.l1_write_data = 32'h1234_5678;
        for (int c = 1; c <= 3; c++) begin
            tick;
            if (c == 3) begin
                l2.l2_resp_valid = 1'b1; l2.l2_resp_data = 32'h0;
            end
            smp;
            total++; if (l2.l1_req_valid !== 1'b1 || l2.l1_req_op !== 1'b1 || l2.l1_req_addr !== 32'h40 || l2.l1_write_data !== 32'h1234_5678)
                $display("FAIL write_wait%0d got %b %b %h %h exp 1 1 00000040 12345678", c, l2.l1_req_valid, l2.l1_req_op, l2.l1_req_addr, l2.l1_write_data); else passed++;
        end
        total++; if (r0.l2_resp_valid !== 1'b1) $display("FAIL write_resp got %b exp 1", r0.l2_resp_valid); else passed++;
        tick;
        l2.l2_resp_valid = 1'b0; r0.l1_req_valid = 1'b0;
        smp;
        total++; if (l2.l1_write_data !== 32'h0 || l2.l1_req_op !== 1'b0)
            $display("FAIL write_done got %h %b exp 0 0", l2.l1_write_data, l2.l1_req_op); else passed++;
        tick; smp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_late_drop;
        test_reset_mid_wait;
        test_write;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
